// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin SRAM arbiter with power-on clear
// Port 0 is read-only, port 1 reads/writes; grants are combinational, reads return one cycle later.
module sram_arbiter #(
  parameter int WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [13:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [13:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        sram_ceb,
  output logic        sram_web,
  output logic [13:0] sram_a,
  output logic [31:0] sram_d,
  output logic [31:0] sram_bweb,
  input  logic [31:0] sram_q,
  output logic        init_done
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [13:0] LAST_ADDR = 14'(WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [13:0] clr_cnt;
  logic        last_gnt;
  logic        tag_valid;
  logic        tag_port;
  logic        rd_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      clr_cnt   <= 14'd0;
      last_gnt  <= 1'b1;
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tag_valid <= rd_gnt;
      tag_port  <= m1_gnt;
      if (state == INIT) begin
        clr_cnt <= clr_cnt + 14'd1;
      end
      if (m0_gnt || m1_gnt) begin
        last_gnt <= m1_gnt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_a    = 14'd0;
    sram_d    = 32'd0;
    sram_bweb = 32'hFFFF_FFFF;
    case (state)
      INIT: begin
        // The state register already sits in INIT during reset; gate the clear strobes too.
        if (!rst) begin
          sram_ceb  = 1'b0;
          sram_web  = 1'b0;
          sram_a    = clr_cnt;
          sram_bweb = 32'd0;
          if (clr_cnt == LAST_ADDR) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        m0_gnt = m0_req && (!m1_req || last_gnt);
        m1_gnt = m1_req && (!m0_req || !last_gnt);
        rd_gnt = m0_gnt || (m1_gnt && !m1_we);
        if (m0_gnt) begin
          sram_ceb = 1'b0;
          sram_a   = m0_addr;
        end else if (m1_gnt) begin
          sram_ceb = 1'b0;
          sram_a   = m1_addr;
          if (m1_we) begin
            sram_web = 1'b0;
            sram_d   = m1_wdata;
            for (int i = 0; i < 4; i++) begin
              sram_bweb[8*i +: 8] = {8{~m1_wstrb[i]}};
            end
          end
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign init_done = (state == RUN);
  assign m0_rvalid = tag_valid && !tag_port;
  assign m1_rvalid = tag_valid && tag_port;
  assign m0_rdata  = sram_q;
  assign m1_rdata  = sram_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req;
  logic [13:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [13:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        sram_ceb;
  logic        sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_bweb;
  logic [31:0] sram_q;
  logic        init_done;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:16383];
  logic [31:0] tab [0:3];

  sram_arbiter #(.WORDS(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_bweb(sram_bweb), .sram_q(sram_q), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hDEAD_BEEF ^ i;
    sram_q = 32'h0;
  end

  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
      else sram_q <= mem[sram_a];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = cycle;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid actual m0=%0b m1=%0b required none", m0_rvalid, m1_rvalid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rvalid_both", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
        check("rvalid_port", {31'd0, m1_rvalid}, {31'd0, e.port});
        check("rdata", e.port ? m1_rdata : m0_rdata, e.data);
        check("rvalid_latency", cycle, e.cyc + 1);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [13:0] a0, input logic r1, input logic we,
                       input logic [13:0] a1, input logic [31:0] wd, input logic [3:0] ws);
    m0_req = r0; m0_addr = a0;
    m1_req = r1; m1_we = we; m1_addr = a1; m1_wdata = wd; m1_wstrb = ws;
  endtask

  task automatic check_init_run();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("init_ceb", {31'd0, sram_ceb}, 32'd0);
      check("init_web", {31'd0, sram_web}, 32'd0);
      check("init_addr", {18'd0, sram_a}, i);
      check("init_bweb", sram_bweb, 32'd0);
      check("init_done_low", {31'd0, init_done}, 32'd0);
      check("init_no_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
      next();
    end
    @(negedge clk);
    check("init_done_high", {31'd0, init_done}, 32'd1);
    check("first_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    check("first_read_web", {31'd0, sram_web}, 32'd1);
    push(1'b0, 32'h0);
  endtask

  initial begin
    tab[0] = 32'h0123_4567;
    tab[1] = 32'h89AB_CDEF;
    tab[2] = 32'hCAFE_F00D;
    tab[3] = 32'h1234_5678;
    rst = 1'b1;
    drive(1'b1, 14'h000, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    check("rst_ceb_web", {30'd0, sram_ceb, sram_web}, 32'd3);
    next();
    rst = 1'b0;
    check_init_run();

    next();
    drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("idle_ceb", {31'd0, sram_ceb}, 32'd1);
    check("idle_bweb", sram_bweb, 32'hFFFF_FFFF);
    check("idle_addr_data", {4'd0, sram_a, sram_d[13:0]}, 32'd0);
    check("idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    next();
    @(negedge clk);
    check("idle_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);

    next();
    drive(1'b0, 14'h0, 1'b1, 1'b1, 14'h005, 32'hAABB_CCDD, 4'b0101);
    @(negedge clk);
    check("wr_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
    check("wr_strobes", {30'd0, sram_ceb, sram_web}, 32'd0);
    check("wr_addr", {18'd0, sram_a}, 32'h5);
    check("wr_data", sram_d, 32'hAABB_CCDD);
    check("wr_bweb", sram_bweb, 32'hFF00_FF00);

    next();
    drive(1'b0, 14'h0, 1'b1, 1'b0, 14'h005, 32'h0, 4'h0);
    @(negedge clk);
    check("rd5_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
    check("rd5_web", {31'd0, sram_web}, 32'd1);
    push(1'b1, 32'h00BB_00DD);

    next();
    drive(1'b0, 14'h0, 1'b1, 1'b1, 14'h005, 32'hFFFF_FFFF, 4'h0);
    @(negedge clk);
    check("wr0_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
    check("wr0_bweb", sram_bweb, 32'hFFFF_FFFF);
    check("wr0_web", {31'd0, sram_web}, 32'd0);

    next();
    drive(1'b0, 14'h0, 1'b1, 1'b0, 14'h005, 32'h0, 4'h0);
    @(negedge clk);
    push(1'b1, 32'h00BB_00DD);

    for (int i = 0; i < 4; i++) begin
      next();
      drive(1'b0, 14'h0, 1'b1, 1'b1, 14'(i), tab[i], 4'hF);
      @(negedge clk);
      check("fill_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
    end

    for (int i = 0; i < 4; i++) begin
      next();
      drive(1'b1, 14'(i), 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("pipe_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
      push(1'b0, tab[i]);
    end

    next();
    drive(1'b0, 14'h0, 1'b1, 1'b0, 14'h004, 32'h0, 4'h0);
    @(negedge clk);
    push(1'b1, 32'h0);

    next();
    drive(1'b1, 14'h000, 1'b1, 1'b0, 14'h001, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("tie_gnt", {30'd0, m0_gnt, m1_gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
      if (k % 2 == 0) push(1'b0, tab[0]);
      else push(1'b1, tab[1]);
      if (k < 3) next();
    end

    next();
    drive(1'b1, 14'h002, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("prerst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    next();
    rst = 1'b1;
    drive(1'b1, 14'h000, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("rst_drop_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    check("rst_mid_done", {31'd0, init_done}, 32'd0);
    next();
    next();
    rst = 1'b0;
    check_init_run();

    next();
    drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    repeat (3) next();
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
